// File: rtl/seq_pkg.sv
// seq_pkg: opcodes, FSM states and IR field positions shared by cpu_sequencer and seq_decode
package seq_pkg;
   localparam logic [2:0] OP_R    = 3'b000;
   localparam logic [2:0] OP_I    = 3'b001;
   localparam logic [2:0] OP_BZ   = 3'b010;
   localparam logic [2:0] OP_BC   = 3'b011;
   localparam logic [2:0] OP_BV   = 3'b100;
   localparam logic [2:0] OP_JMP  = 3'b101;
   localparam logic [2:0] OP_NOP  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;
   localparam int OP_HI  = 15, OP_LO  = 13;
   localparam int ALU_HI = 12, ALU_LO = 10;
   localparam int RD_HI  = 9,  RD_LO  = 7;
   localparam int RS_HI  = 6,  RS_LO  = 4;
   localparam int RT_HI  = 3,  RT_LO  = 1;
   localparam int IMM_HI = 5,  IMM_LO = 0;
   localparam int OFF_HI = 7,  OFF_LO = 0;
`ifdef SEQ_SINGLE_STEP_EN
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_PAUSE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
`endif
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-memory fetch handshake between sequencer and memory
interface cpu_sequencer_if #(parameter int PC_W = 8);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [15:0]     imem_rdata;
   logic            imem_valid;
   modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
   modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/seq_decode.sv
// seq_decode: purely combinational IR -> datapath controls and instruction class
module seq_decode
   import seq_pkg::*;
(
   input  logic [15:0] i_ir,
   output logic [2:0]  o_rs,
   output logic [2:0]  o_rt,
   output logic [2:0]  o_rd,
   output logic [2:0]  o_alu_op,
   output logic        o_select_imm,
   output logic [5:0]  o_immediate,
   output logic [2:0]  o_br_mask,
   output logic        o_is_branch,
   output logic        o_is_jmp,
   output logic        o_is_halt,
   output logic        o_writes_reg
);
   logic [2:0] w_op;
   assign w_op         = i_ir[OP_HI:OP_LO];
   assign o_alu_op     = i_ir[ALU_HI:ALU_LO];
   assign o_rd         = i_ir[RD_HI:RD_LO];
   assign o_rs         = (w_op == OP_I) ? i_ir[RD_HI:RD_LO] : i_ir[RS_HI:RS_LO];
   assign o_rt         = i_ir[RT_HI:RT_LO];
   assign o_immediate  = i_ir[IMM_HI:IMM_LO];
   assign o_select_imm = (w_op == OP_I);
   // one-hot flag selector laid out like the flags register {C,V,Z}
   assign o_br_mask    = {w_op == OP_BC, w_op == OP_BV, w_op == OP_BZ};
   assign o_is_branch  = |o_br_mask;
   assign o_is_jmp     = (w_op == OP_JMP);
   assign o_is_halt    = (w_op == OP_HALT);
   assign o_writes_reg = (w_op == OP_R) || (w_op == OP_I);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/exec control unit owning PC, IR and flags.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after every EXEC.
module cpu_sequencer
   import seq_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic            step,
`endif
   cpu_sequencer_if.master imem,
   output logic [2:0]      rs,
   output logic [2:0]      rt,
   output logic [2:0]      rd,
   output logic [2:0]      alu_op,
   output logic            select_imm,
   output logic [5:0]      immediate,
   output logic            reg_write,
   input  logic            carry,
   input  logic            overflow,
   input  logic            zero,
   output logic [2:0]      flags,
   output logic            busy,
   output logic            halted
);
   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic [2:0]      r_flags;
   logic            r_req, r_exec, r_busy, r_halted;
   logic [2:0]      w_br_mask;
   logic            w_is_branch, w_is_jmp, w_is_halt, w_writes_reg, w_taken;
   logic [PC_W-1:0] w_br_target, w_next_pc;

   seq_decode u_decode (
      .i_ir         (r_ir),
      .o_rs         (rs),
      .o_rt         (rt),
      .o_rd         (rd),
      .o_alu_op     (alu_op),
      .o_select_imm (select_imm),
      .o_immediate  (immediate),
      .o_br_mask    (w_br_mask),
      .o_is_branch  (w_is_branch),
      .o_is_jmp     (w_is_jmp),
      .o_is_halt    (w_is_halt),
      .o_writes_reg (w_writes_reg)
   );

   // branches look only at latched flags, never at this cycle's ALU outputs
   assign w_taken     = w_is_branch && |(w_br_mask & r_flags);
   assign w_br_target = PC_W'(32'(r_pc) + 32'd1 + {{24{r_ir[OFF_HI]}}, r_ir[OFF_HI:OFF_LO]});
   assign w_next_pc   = w_is_jmp ? PC_W'(r_ir) : w_taken ? w_br_target : r_pc + PC_W'(1);

   assign imem.imem_req  = r_req;
   assign imem.imem_addr = r_pc;
   assign reg_write      = r_exec && w_writes_reg;
   assign flags          = r_flags;
   assign busy           = r_busy;
   assign halted         = r_halted;

   // sequencer FSM with PC, IR, flags and registered handshake/status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_flags  <= '0;
         r_req    <= 1'b0;
         r_exec   <= 1'b0;
         r_busy   <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_HALT: if (start) begin
               r_state  <= S_FETCH;
               r_pc     <= RESET_PC;
               r_flags  <= '0;
               r_req    <= 1'b1;
               r_busy   <= 1'b1;
               r_halted <= 1'b0;
            end
            S_FETCH: if (imem.imem_valid) begin
               r_ir    <= imem.imem_rdata;
               r_state <= S_EXEC;
               r_req   <= 1'b0;
               r_exec  <= 1'b1;
            end
            S_EXEC: begin
               r_exec <= 1'b0;
               if (w_writes_reg) r_flags <= {carry, overflow, zero};
               if (w_is_halt) begin
                  r_state  <= S_HALT;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else begin
                  r_pc <= w_next_pc;
`ifdef SEQ_SINGLE_STEP_EN
                  r_state <= S_PAUSE;
                  r_busy  <= 1'b0;
`else
                  r_state <= S_FETCH;
                  r_req   <= 1'b1;
`endif
               end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: if (step) begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
               r_busy  <= 1'b1;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: instruction-level reference model with directed and random programs
module tb_cpu_sequencer;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic carry = 1'b0, overflow = 1'b0, zero = 1'b0;
   logic [2:0] rs, rt, rd, alu_op, flags;
   logic select_imm, reg_write, busy, halted;
   logic [5:0] immediate;
   int checks = 0, failures = 0;

   cpu_sequencer_if #(.PC_W(8)) imem ();

   cpu_sequencer #(.PC_W(8), .RESET_PC(8'd0)) dut (
      .clk(clk), .rst(rst), .start(start), .imem(imem),
      .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .select_imm(select_imm),
      .immediate(immediate), .reg_write(reg_write),
      .carry(carry), .overflow(overflow), .zero(zero),
      .flags(flags), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   // program memory and architectural model
   logic [15:0] mem [256];
   logic [7:0]  m_pc = 8'd0;
   logic [15:0] m_ir = 16'd0;
   logic [2:0]  m_flags = 3'd0;
   logic        m_busy = 1'b0, m_halted = 1'b0, m_fetch = 1'b0, m_exec = 1'b0;
   // stimulus controls
   logic        fix_flags = 1'b1, fc = 1'b0, fv = 1'b0, fz = 1'b0;
   logic        pend_start = 1'b0, rand_start = 1'b0;
   int          wait_pct = 0, force_wait = 0;
   logic        was_exec = 1'b0;
   logic [15:0] was_ir = 16'd0;

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 8'd0; m_ir = 16'd0; m_flags = 3'd0;
      m_busy = 1'b0; m_halted = 1'b0; m_fetch = 1'b0; m_exec = 1'b0;
   endtask

   task automatic fill_mem(logic [15:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   // one cycle: check outputs against model, drive next inputs, advance model
   task automatic tick();
      logic [2:0] op;
      logic v;
      int off, t;
      @(negedge clk);
      op = m_ir[15:13];
      chk("busy", 16'(busy), 16'(m_busy));
      chk("halted", 16'(halted), 16'(m_halted));
      chk("flags", 16'(flags), 16'(m_flags));
      chk("imem_req", 16'(imem.imem_req), 16'(m_fetch));
      if (m_fetch) chk("imem_addr", 16'(imem.imem_addr), 16'(m_pc));
      chk("reg_write", 16'(reg_write), 16'(m_exec && op <= 3'd1));
      chk("rd", 16'(rd), 16'(m_ir[9:7]));
      chk("rs", 16'(rs), 16'(op == 3'd1 ? m_ir[9:7] : m_ir[6:4]));
      chk("rt", 16'(rt), 16'(m_ir[3:1]));
      chk("alu_op", 16'(alu_op), 16'(m_ir[12:10]));
      chk("immediate", 16'(immediate), 16'(m_ir[5:0]));
      chk("select_imm", 16'(select_imm), 16'(op == 3'd1));
      was_exec = m_exec;
      was_ir = m_ir;
      start = pend_start || (rand_start && $urandom_range(19) == 0);
      pend_start = 1'b0;
      {carry, overflow, zero} = fix_flags ? {fc, fv, fz} : 3'($urandom);
      v = m_fetch && (force_wait > 0 ? 1'b0 : ($urandom_range(99) >= 32'(wait_pct)));
      if (m_fetch && force_wait > 0) force_wait--;
      imem.imem_valid = v;
      imem.imem_rdata = v ? mem[m_pc] : 16'($urandom);
      if (m_exec) begin
         m_exec = 1'b0;
         if (op <= 3'd1) m_flags = {carry, overflow, zero};
         if (op == 3'd7) begin
            m_busy = 1'b0;
            m_halted = 1'b1;
         end else begin
            m_fetch = 1'b1;
            if (op == 3'd5) m_pc = m_ir[7:0];
            else if ((op == 3'd2 && m_flags[0]) || (op == 3'd3 && m_flags[2]) || (op == 3'd4 && m_flags[1])) begin
               off = $signed(m_ir[7:0]);
               t = int'(m_pc) + 1 + off;
               m_pc = 8'(t);
            end else m_pc = m_pc + 8'd1;
         end
      end else if (m_fetch) begin
         if (v) begin
            m_ir = mem[m_pc];
            m_fetch = 1'b0;
            m_exec = 1'b1;
         end
      end else if (start) begin
         m_pc = 8'd0; m_flags = 3'd0;
         m_fetch = 1'b1; m_busy = 1'b1; m_halted = 1'b0;
      end
   endtask

   task automatic run_to_exec(logic [15:0] ir);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(was_exec && was_ir == ir) && n < 60);
      chk("exec_reached", 16'(was_exec && was_ir == ir), 16'd1);
   endtask

   initial begin
      imem.imem_valid = 1'b0;
      imem.imem_rdata = 16'd0;
      fill_mem(16'hE000);
      @(negedge clk);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_halted", 16'(halted), 16'd0);
      chk("rst_req", 16'(imem.imem_req), 16'd0);
      chk("rst_addr", 16'(imem.imem_addr), 16'd0);
      chk("rst_flags", 16'(flags), 16'd0);
      chk("rst_reg_write", 16'(reg_write), 16'd0);
      rst = 1'b0;

      // program 1: R with Z=1, I-type, JMP 5, BZ -2 taken, HALT at 4
      mem[0] = 16'h0000; mem[1] = 16'h2485; mem[2] = 16'hA005;
      mem[5] = 16'h40FE; mem[4] = 16'hE000;
      fc = 1'b0; fv = 1'b0; fz = 1'b1;
      pend_start = 1'b1;
      tick();
      tick();
      chk("p1_first_req", 16'(imem.imem_req), 16'd1);
      chk("p1_first_addr", 16'(imem.imem_addr), 16'd0);
      run_to_exec(16'h0000);
      chk("p1_r_reg_write", 16'(reg_write), 16'd1);
      chk("p1_r_fields", {4'd0, rd, rs, rt, alu_op}, 16'd0);
      run_to_exec(16'h2485);
      chk("p1_i_rs", 16'(rs), 16'd1);
      chk("p1_i_rd", 16'(rd), 16'd1);
      chk("p1_i_imm", 16'(immediate), 16'd5);
      chk("p1_i_sel", 16'(select_imm), 16'd1);
      chk("p1_i_rw", 16'(reg_write), 16'd1);
      run_to_exec(16'hA005);
      run_to_exec(16'h40FE);
      chk("p1_bz_rw", 16'(reg_write), 16'd0);
      tick();
      chk("p1_bz_taken_addr", 16'(imem.imem_addr), 16'd4);
      run_to_exec(16'hE000);
      tick();
      chk("p1_halted", 16'(halted), 16'd1);
      chk("p1_busy", 16'(busy), 16'd0);
      chk("p1_flags", 16'(flags), 16'd1);

      // program 2: same branch with Z=0, not taken
      fill_mem(16'hE000);
      mem[0] = 16'h0000; mem[1] = 16'hA005; mem[5] = 16'h40FE;
      fz = 1'b0;
      pend_start = 1'b1;
      tick();
      tick();
      chk("p2_restart_flags", 16'(flags), 16'd0);
      chk("p2_restart_addr", 16'(imem.imem_addr), 16'd0);
      run_to_exec(16'h40FE);
      tick();
      chk("p2_bz_fall_addr", 16'(imem.imem_addr), 16'd6);
      run_to_exec(16'hE000);

      // program 3: JMP FF, NOP wraps to 0, wait states, then async reset mid-fetch
      fill_mem(16'hE000);
      mem[0] = 16'hA0FF; mem[255] = 16'hC000;
      pend_start = 1'b1;
      run_to_exec(16'hA0FF);
      run_to_exec(16'hC000);
      mem[0] = 16'h0000;
      fz = 1'b1;
      force_wait = 3;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("p3_wait_req", 16'(imem.imem_req), 16'd1);
         chk("p3_wrap_addr", 16'(imem.imem_addr), 16'd0);
         chk("p3_wait_rw", 16'(reg_write), 16'd0);
      end
      run_to_exec(16'h0000);
      force_wait = 1;
      tick();
      chk("p3_pre_rst_addr", 16'(imem.imem_addr), 16'd1);
      chk("p3_pre_rst_flags", 16'(flags), 16'd1);
      imem.imem_valid = 1'b1;
      imem.imem_rdata = 16'h2485;
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 16'(busy), 16'd0);
      chk("arst_req", 16'(imem.imem_req), 16'd0);
      chk("arst_addr", 16'(imem.imem_addr), 16'd0);
      chk("arst_flags", 16'(flags), 16'd0);
      chk("arst_rd", 16'(rd), 16'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("late_valid_req", 16'(imem.imem_req), 16'd0);
      chk("late_valid_busy", 16'(busy), 16'd0);
      chk("late_valid_rw", 16'(reg_write), 16'd0);
      chk("late_valid_ir", {rd, rs, 4'd0, select_imm, immediate}, 16'd0);
      tick();

      // random programs, random wait states, random flags and start pulses
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      fix_flags = 1'b0;
      wait_pct = 30;
      rand_start = 1'b1;
      pend_start = 1'b1;
      repeat (3000) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
